// File: rtl/sdram_burst_sched.sv
// sdram_burst_sched: shares one SDRAM controller between the write and read
// FIFO channels, issuing fixed bursts and generating circular addresses.
module sdram_burst_sched #(
    parameter int          WR_BURST      = 256,
    parameter int          RD_BURST      = 256,
    parameter int          RD_FIFO_DEPTH = 1024,
    parameter logic [20:0] WR_BASE       = 21'h000000,
    parameter logic [20:0] WR_END        = 21'h04B000,
    parameter logic [20:0] RD_BASE       = 21'h000000,
    parameter logic [20:0] RD_END        = 21'h04B000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_init_done,
    input  logic [9:0]  wr_fifo_level,
    input  logic [10:0] rd_fifo_level,
    input  logic        wr_load,
    input  logic        rd_load,
    output logic        sdram_wr_req,
    input  logic        sdram_wr_ack,
    output logic [20:0] sdram_wr_addr,
    output logic [8:0]  sdram_wr_burst,
    output logic        sdram_rd_req,
    input  logic        sdram_rd_ack,
    output logic [20:0] sdram_rd_addr,
    output logic [9:0]  sdram_rd_burst,
    output logic        busy
);

    typedef enum logic [1:0] {INIT, IDLE, WR, RD} state_t;

    state_t      state;
    state_t      state_n;
    logic        last_rd;
    logic        wr_pend;
    logic        rd_pend;
    logic        wr_ack_d;
    logic        rd_ack_d;
    logic [20:0] wr_addr;
    logic [20:0] rd_addr;
    logic [20:0] wr_step;
    logic [20:0] rd_step;
    logic [20:0] wr_next;
    logic [20:0] rd_next;
    logic        wr_ok;
    logic        rd_ok;
    logic        rd_urgent;
    logic        wr_done;
    logic        rd_done;

    assign wr_ok     = wr_fifo_level >= 10'(WR_BURST);
    assign rd_ok     = rd_fifo_level <= 11'(RD_FIFO_DEPTH - RD_BURST);
    assign rd_urgent = rd_fifo_level < 11'(RD_BURST);

    // burst ends on the falling edge of the channel's own ack
    assign wr_done = (state == WR) && wr_ack_d && !sdram_wr_ack;
    assign rd_done = (state == RD) && rd_ack_d && !sdram_rd_ack;

    assign wr_step = wr_addr + 21'(WR_BURST);
    assign rd_step = rd_addr + 21'(RD_BURST);
    assign wr_next = (wr_step >= WR_END) ? WR_BASE : wr_step;
    assign rd_next = (rd_step >= RD_END) ? RD_BASE : rd_step;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= INIT;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            INIT: if (sdram_init_done) state_n = IDLE;
            IDLE: begin
                if (wr_ok && rd_ok)
                    state_n = (rd_urgent || !last_rd) ? RD : WR;
                else if (wr_ok)
                    state_n = WR;
                else if (rd_ok)
                    state_n = RD;
            end
            WR:   if (wr_done) state_n = IDLE;
            RD:   if (rd_done) state_n = IDLE;
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_rd  <= 1'b1;
            wr_pend  <= 1'b0;
            rd_pend  <= 1'b0;
            wr_ack_d <= 1'b0;
            rd_ack_d <= 1'b0;
            wr_addr  <= WR_BASE;
            rd_addr  <= RD_BASE;
        end else begin
            // acks outside their own state never arm a completion
            wr_ack_d <= (state == WR) && sdram_wr_ack;
            rd_ack_d <= (state == RD) && sdram_rd_ack;
            if (wr_done) begin
                last_rd <= 1'b0;
                wr_pend <= 1'b0;
                wr_addr <= (wr_pend || wr_load) ? WR_BASE : wr_next;
            end else if (wr_load) begin
                if (state == WR) wr_pend <= 1'b1;
                else             wr_addr <= WR_BASE;
            end
            if (rd_done) begin
                last_rd <= 1'b1;
                rd_pend <= 1'b0;
                rd_addr <= (rd_pend || rd_load) ? RD_BASE : rd_next;
            end else if (rd_load) begin
                if (state == RD) rd_pend <= 1'b1;
                else             rd_addr <= RD_BASE;
            end
        end
    end

    assign sdram_wr_req   = (state == WR);
    assign sdram_rd_req   = (state == RD);
    assign busy           = (state == WR) || (state == RD);
    assign sdram_wr_addr  = wr_addr;
    assign sdram_rd_addr  = rd_addr;
    assign sdram_wr_burst = 9'(WR_BURST);
    assign sdram_rd_burst = 10'(RD_BURST);

`ifndef SYNTHESIS
    localparam int WR_SPAN = int'(WR_END) - int'(WR_BASE);
    localparam int RD_SPAN = int'(RD_END) - int'(RD_BASE);

    always @(posedge clk) begin
        assert (WR_SPAN % WR_BURST == 0);
        assert (RD_SPAN % RD_BURST == 0);
    end
`endif

endmodule

// File: tb/tb_sdram_burst_sched.sv
// tb_sdram_burst_sched: scoreboard bench for the SDRAM burst scheduler
// using a 0x300-word region so address wrap is reached quickly.
module tb_sdram_burst_sched;

    localparam int          BL   = 256;
    localparam logic [20:0] REND = 21'h300;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sdram_init_done;
    logic [9:0]  wr_fifo_level;
    logic [10:0] rd_fifo_level;
    logic        wr_load;
    logic        rd_load;
    logic        sdram_wr_req;
    logic        sdram_wr_ack;
    logic [20:0] sdram_wr_addr;
    logic [8:0]  sdram_wr_burst;
    logic        sdram_rd_req;
    logic        sdram_rd_ack;
    logic [20:0] sdram_rd_addr;
    logic [9:0]  sdram_rd_burst;
    logic        busy;

    int          total = 0;
    int          bad   = 0;
    logic [21:0] exp_q[$];
    logic [20:0] exp_rd;

    always #5 clk = ~clk;

    sdram_burst_sched #(
        .WR_BURST      (BL),
        .RD_BURST      (BL),
        .RD_FIFO_DEPTH (1024),
        .WR_BASE       (21'h0),
        .WR_END        (REND),
        .RD_BASE       (21'h0),
        .RD_END        (REND)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .wr_fifo_level   (wr_fifo_level),
        .rd_fifo_level   (rd_fifo_level),
        .wr_load         (wr_load),
        .rd_load         (rd_load),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_wr_addr   (sdram_wr_addr),
        .sdram_wr_burst  (sdram_wr_burst),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_rd_addr   (sdram_rd_addr),
        .sdram_rd_burst  (sdram_rd_burst),
        .busy            (busy)
    );

    function automatic logic [20:0] step(input logic [20:0] a);
        logic [20:0] s;
        s = a + 21'(BL);
        return (s >= REND) ? 21'h0 : s;
    endfunction

    // one full burst: pop expectation, ack, glitch the other ack, release
    task automatic burst(input int nwr, input int nrd,
                         input bit load, input bit chk_gap);
        int          w;
        logic [21:0] e;
        logic [21:0] got;
        bit          is_rd;
        logic [20:0] a;
        logic [20:0] na;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(sdram_wr_req || sdram_rd_req) && w < 40);
        total++;
        if (!(sdram_wr_req || sdram_rd_req)) begin
            bad++;
            $display("FAIL req_timeout: got no req after %0d cycles, want req", w);
            return;
        end
        e = 22'h3fffff;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        is_rd = sdram_rd_req;
        a     = is_rd ? sdram_rd_addr : sdram_wr_addr;
        got   = {is_rd, a};
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL grant: got rd=%0b addr=%h, want rd=%0b addr=%h",
                     got[21], got[20:0], e[21], e[20:0]);
        end
        total++;
        if ((sdram_wr_req & sdram_rd_req) !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL req_excl: got wr=%0b rd=%0b busy=%0b, want one req and busy",
                     sdram_wr_req, sdram_rd_req, busy);
        end
        if (chk_gap) begin
            total++;
            if (w != 1) begin
                bad++;
                $display("FAIL gap: got %0d cycles to req, want 1", w);
            end
        end
        if (is_rd) sdram_rd_ack = 1'b1;
        else       sdram_wr_ack = 1'b1;
        repeat (BL / 2) @(negedge clk);
        if (is_rd) begin sdram_wr_ack = 1'b1; rd_load = load; end
        else       begin sdram_rd_ack = 1'b1; wr_load = load; end
        @(negedge clk);
        if (is_rd) begin sdram_wr_ack = 1'b0; rd_load = 1'b0; end
        else       begin sdram_rd_ack = 1'b0; wr_load = 1'b0; end
        total++;
        if ((is_rd ? sdram_rd_req : sdram_wr_req) !== 1'b1 ||
            (is_rd ? sdram_rd_addr : sdram_wr_addr) !== a) begin
            bad++;
            $display("FAIL hold: got req=%0b addr=%h, want req=1 addr=%h",
                     is_rd ? sdram_rd_req : sdram_wr_req,
                     is_rd ? sdram_rd_addr : sdram_wr_addr, a);
        end
        repeat (BL / 2 - 1) @(negedge clk);
        wr_fifo_level = 10'(nwr);
        rd_fifo_level = 11'(nrd);
        sdram_wr_ack  = 1'b0;
        sdram_rd_ack  = 1'b0;
        @(negedge clk);
        na = load ? 21'h0 : step(a);
        total++;
        if (sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0 || busy !== 1'b0 ||
            (is_rd ? sdram_rd_addr : sdram_wr_addr) !== na) begin
            bad++;
            $display("FAIL release: got wr=%0b rd=%0b busy=%0b addr=%h, want 0 0 0 addr=%h",
                     sdram_wr_req, sdram_rd_req, busy,
                     is_rd ? sdram_rd_addr : sdram_wr_addr, na);
        end
        if (is_rd) exp_rd = na;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        sdram_init_done = 1'b0;
        wr_fifo_level   = 10'd300;
        rd_fifo_level   = 11'd1024;
        wr_load         = 1'b0;
        rd_load         = 1'b0;
        sdram_wr_ack    = 1'b0;
        sdram_rd_ack    = 1'b0;
        exp_rd          = 21'h0;
        repeat (3) @(negedge clk);
        total++;
        if ({sdram_wr_req, sdram_rd_req, busy} !== 3'b000) begin
            bad++;
            $display("FAIL reset_req: got %b, want 000",
                     {sdram_wr_req, sdram_rd_req, busy});
        end
        total++;
        if (sdram_wr_addr !== 21'h0 || sdram_rd_addr !== 21'h0) begin
            bad++;
            $display("FAIL reset_addr: got wr=%h rd=%h, want 0 0",
                     sdram_wr_addr, sdram_rd_addr);
        end
        total++;
        if (sdram_wr_burst !== 9'd256 || sdram_rd_burst !== 10'd256) begin
            bad++;
            $display("FAIL burst_len: got %0d %0d, want 256 256",
                     sdram_wr_burst, sdram_rd_burst);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_init_gating();
        int errs;
        errs = 0;
        repeat (50) begin
            @(negedge clk);
            if (sdram_wr_req || sdram_rd_req || busy) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL init_gate: got %0d req cycles, want 0", errs);
        end
        sdram_init_done = 1'b1;
        @(negedge clk);
        total++;
        if (sdram_wr_req !== 1'b0) begin
            bad++;
            $display("FAIL init_early: got wr_req=%0b, want 0", sdram_wr_req);
        end
        @(negedge clk);
        total++;
        if (sdram_wr_req !== 1'b1 || sdram_wr_addr !== 21'h0) begin
            bad++;
            $display("FAIL init_req: got wr_req=%0b addr=%h, want 1 0",
                     sdram_wr_req, sdram_wr_addr);
        end
    endtask

    task automatic test_write_wrap();
        exp_q.push_back({1'b0, 21'h000});
        exp_q.push_back({1'b0, 21'h100});
        exp_q.push_back({1'b0, 21'h200});
        exp_q.push_back({1'b0, 21'h000});
        burst(300, 1024, 1'b0, 1'b0);
        burst(300, 1024, 1'b0, 1'b1);
        burst(300, 1024, 1'b0, 1'b1);
        burst(0, 1024, 1'b0, 1'b1);
    endtask

    task automatic test_round_robin();
        wr_fifo_level = 10'd512;
        rd_fifo_level = 11'd400;
        exp_q.push_back({1'b1, 21'h000});
        exp_q.push_back({1'b0, 21'h100});
        exp_q.push_back({1'b1, 21'h100});
        exp_q.push_back({1'b0, 21'h200});
        burst(512, 400, 1'b0, 1'b0);
        burst(512, 400, 1'b0, 1'b1);
        burst(512, 400, 1'b0, 1'b1);
        burst(0, 1024, 1'b0, 1'b1);
    endtask

    task automatic test_rd_load_idle();
        total++;
        if (sdram_rd_addr !== exp_rd) begin
            bad++;
            $display("FAIL rd_addr_pre: got %h, want %h", sdram_rd_addr, exp_rd);
        end
        rd_load = 1'b1;
        @(negedge clk);
        rd_load = 1'b0;
        exp_rd  = 21'h0;
        total++;
        if (sdram_rd_addr !== exp_rd || busy !== 1'b0) begin
            bad++;
            $display("FAIL rd_load: got addr=%h busy=%0b, want %h 0",
                     sdram_rd_addr, busy, exp_rd);
        end
    endtask

    task automatic test_urgency();
        wr_fifo_level = 10'd0;
        rd_fifo_level = 11'd400;
        exp_q.push_back({1'b1, 21'h000});
        exp_q.push_back({1'b1, 21'h100});
        exp_q.push_back({1'b0, 21'h000});
        burst(512, 100, 1'b0, 1'b0);
        burst(512, 400, 1'b0, 1'b1);
        burst(0, 1024, 1'b0, 1'b1);
    endtask

    task automatic test_deferred_load();
        wr_fifo_level = 10'd300;
        exp_q.push_back({1'b0, 21'h100});
        exp_q.push_back({1'b0, 21'h000});
        burst(300, 1024, 1'b1, 1'b0);
        burst(0, 1024, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_burst();
        int w;
        int errs;
        rd_fifo_level = 11'd400;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!sdram_rd_req && w < 40);
        total++;
        if (sdram_rd_req !== 1'b1 || sdram_rd_addr !== exp_rd) begin
            bad++;
            $display("FAIL mid_req: got rd_req=%0b addr=%h, want 1 %h",
                     sdram_rd_req, sdram_rd_addr, exp_rd);
        end
        sdram_rd_ack = 1'b1;
        repeat (20) @(negedge clk);
        rst_n           = 1'b0;
        sdram_init_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if ({sdram_wr_req, sdram_rd_req, busy} !== 3'b000 ||
            sdram_wr_addr !== 21'h0 || sdram_rd_addr !== 21'h0) begin
            bad++;
            $display("FAIL mid_reset: got req=%b wr=%h rd=%h, want 000 0 0",
                     {sdram_wr_req, sdram_rd_req, busy}, sdram_wr_addr, sdram_rd_addr);
        end
        sdram_rd_ack = 1'b0;
        errs = 0;
        repeat (10) begin
            @(negedge clk);
            if (sdram_wr_req || sdram_rd_req || busy) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL mid_init: got %0d req cycles, want 0", errs);
        end
        exp_rd          = 21'h0;
        sdram_init_done = 1'b1;
        exp_q.push_back({1'b1, 21'h000});
        burst(0, 1024, 1'b0, 1'b0);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue: got %0d left, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_init_gating();
        test_write_wrap();
        test_round_robin();
        test_rd_load_idle();
        test_urgency();
        test_deferred_load();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
